// File: rtl/mem_access_unit.sv
// Load/store front end for a word-addressed unified memory.
// Turns byte/halfword/word requests into word-aligned memory transactions.
// Sub-word stores use read-modify-write. Loads are extracted and extended.
// Rejected accesses never reach the memory.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   req, we_req          request strobe and store select, sampled while idle
//   funct3, addr, wdata  RISC-V width code, byte address, LSB-aligned store data
//   busy, done, err      in-flight flag, completion pulse, rejection flag (with done)
//   rdata                registered, extended load result
//   mem_a, mem_wd        word-aligned memory address and write data
//   mem_we, mem_rd       memory write enable and combinational read data
module mem_access_unit #(
  parameter int unsigned MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we_req,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  output logic        mem_we,
  input  logic [31:0] mem_rd
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

  state_e      state_q, state_d;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] word_q;
  logic        err_q;
  logic [31:0] rdata_q;

  // Rejection check on the incoming (not yet latched) request.
  logic req_err;
  always_comb begin
    req_err = 1'b0;
    unique case (funct3)
      3'b000, 3'b100: req_err = 1'b0;
      3'b001, 3'b101: req_err = addr[0];
      3'b010:         req_err = (addr[1:0] != 2'b00);
      default:        req_err = 1'b1;
    endcase
    if (we_req && funct3[2]) req_err = 1'b1;
    if ({2'b00, addr[31:2]} >= MEM_WORDS) req_err = 1'b1;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          if (req_err)                          state_d = StDone;
          else if (we_req && funct3 == 3'b010)  state_d = StWrite;
          else                                  state_d = StRead;
        end
      end
      StRead:  state_d = we_q ? StWrite : StDone;
      StWrite: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Load extraction from the live memory word.
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_val;
  always_comb begin
    unique case (addr_q[1:0])
      2'b00:   ld_byte = mem_rd[7:0];
      2'b01:   ld_byte = mem_rd[15:8];
      2'b10:   ld_byte = mem_rd[23:16];
      default: ld_byte = mem_rd[31:24];
    endcase
    ld_half = addr_q[1] ? mem_rd[31:16] : mem_rd[15:0];
    unique case (funct3_q[1:0])
      2'b00:   ld_val = funct3_q[2] ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'b01:   ld_val = funct3_q[2] ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_val = mem_rd;
    endcase
  end

  // Request latches, read capture and load result.
  always_ff @(posedge clk) begin
    if (reset) begin
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      word_q   <= 32'h0;
      err_q    <= 1'b0;
      rdata_q  <= 32'h0;
    end else begin
      if (state_q == StIdle && req) begin
        we_q     <= we_req;
        funct3_q <= funct3;
        addr_q   <= addr;
        wdata_q  <= wdata;
        err_q    <= req_err;
      end
      if (state_q == StRead) begin
        word_q <= mem_rd;
        if (!we_q) rdata_q <= ld_val;
      end
    end
  end

  // Store merge: only the addressed lane of the previously read word changes.
  logic [31:0] merged;
  always_comb begin
    merged = word_q;
    unique case (funct3_q[1:0])
      2'b00: begin
        unique case (addr_q[1:0])
          2'b00:   merged[7:0]   = wdata_q[7:0];
          2'b01:   merged[15:8]  = wdata_q[7:0];
          2'b10:   merged[23:16] = wdata_q[7:0];
          default: merged[31:24] = wdata_q[7:0];
        endcase
      end
      2'b01: begin
        if (addr_q[1]) merged[31:16] = wdata_q[15:0];
        else           merged[15:0]  = wdata_q[15:0];
      end
      default: merged = wdata_q;
    endcase
  end

  // Outputs decoded from the state register.
  always_comb begin
    busy   = (state_q != StIdle);
    done   = (state_q == StDone);
    err    = (state_q == StDone) && err_q;
    mem_we = (state_q == StWrite);
    mem_wd = (state_q == StWrite) ? merged : 32'h0;
    mem_a  = {addr_q[31:2], 2'b00};
    rdata  = rdata_q;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset, req, we_req;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        busy, done, err, mem_we;
  logic [31:0] rdata, mem_a, mem_wd, mem_rd;

  int total = 0;
  int bad = 0;

  logic [31:0] mem [0:63];
  logic        pl_en = 1'b0;
  logic [5:0]  pl_idx = 6'd0;
  logic [31:0] pl_data = 32'h0;

  always #5 clk = ~clk;

  assign mem_rd = mem[mem_a[7:2]];

  always @(posedge clk) begin
    if (pl_en)       mem[pl_idx] <= pl_data;
    else if (mem_we) mem[mem_a[7:2]] <= mem_wd;
  end

  mem_access_unit #(.MEM_WORDS(64)) dut (
    .clk(clk), .reset(reset), .req(req), .we_req(we_req), .funct3(funct3),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err),
    .rdata(rdata), .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd)
  );

  task automatic preload(input logic [5:0] idx, input logic [31:0] data);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = idx; pl_data = data;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Issue one request; report done latency (0 = timeout), write cycles, err and
  // whether mem_we was high in the first post-accept cycle.
  task automatic run(input logic w, input logic [2:0] f, input logic [31:0] a,
                     input logic [31:0] d, output int lat, output int wecnt,
                     output logic e, output logic we1);
    @(negedge clk);
    req = 1'b1; we_req = w; funct3 = f; addr = a; wdata = d;
    lat = 0; wecnt = 0; e = 1'b0; we1 = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      req = 1'b0;
      if (n == 1) we1 = mem_we;
      if (mem_we) wecnt++;
      if (done) begin
        lat = n; e = err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 1'b0; we_req = 1'b0; funct3 = 3'b000; addr = 32'h0; wdata = 32'h0;
    repeat (2) @(negedge clk);
    total++; if ({busy, done, err, mem_we} !== 4'b0000) begin bad++;
      $display("FAIL reset_ctl got=%b want=0000", {busy, done, err, mem_we}); end
    total++; if (rdata !== 32'h0) begin bad++;
      $display("FAIL reset_rdata got=%h want=00000000", rdata); end
    total++; if ({mem_wd, mem_a} !== 64'h0) begin bad++;
      $display("FAIL reset_mem_bus got=%h/%h want=0/0", mem_wd, mem_a); end
    reset = 1'b0;
  endtask

  task automatic test_loads();
    logic [2:0]  f3  [6] = '{3'b000, 3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    logic [31:0] ad  [6] = '{32'h24, 32'h25, 32'h25, 32'h26, 32'h26, 32'h24};
    logic [31:0] exp [6] = '{32'h0000007F, 32'hFFFFFFFF, 32'h000000FF,
                             32'hFFFF8000, 32'h00008000, 32'h8000FF7F};
    int lat, wc; logic e, w1;
    preload(6'd9, 32'h8000FF7F);
    for (int i = 0; i < 6; i++) begin
      run(1'b0, f3[i], ad[i], 32'h0, lat, wc, e, w1);
      total++; if (lat !== 2) begin bad++;
        $display("FAIL load%0d_latency got=%0d want=2", i, lat); end
      total++; if (e !== 1'b0 || wc !== 0) begin bad++;
        $display("FAIL load%0d_err_we got=%b/%0d want=0/0", i, e, wc); end
      total++; if (rdata !== exp[i]) begin bad++;
        $display("FAIL load%0d_rdata got=%h want=%h", i, rdata, exp[i]); end
    end
  endtask

  task automatic test_subword_stores();
    int lat, wc; logic e, w1;
    preload(6'd8, 32'h12345678);
    run(1'b1, 3'b000, 32'h22, 32'hFFFFFFAB, lat, wc, e, w1);
    total++; if (lat !== 3 || wc !== 1 || e !== 1'b0) begin bad++;
      $display("FAIL sb_timing got=lat%0d we%0d err%b want=lat3 we1 err0", lat, wc, e); end
    total++; if (mem[8] !== 32'h12AB5678) begin bad++;
      $display("FAIL sb_word got=%h want=12AB5678", mem[8]); end
    preload(6'd8, 32'h12345678);
    run(1'b1, 3'b001, 32'h20, 32'h0000BEEF, lat, wc, e, w1);
    total++; if (lat !== 3 || wc !== 1 || e !== 1'b0) begin bad++;
      $display("FAIL sh_timing got=lat%0d we%0d err%b want=lat3 we1 err0", lat, wc, e); end
    total++; if (mem[8] !== 32'h1234BEEF) begin bad++;
      $display("FAIL sh_word got=%h want=1234BEEF", mem[8]); end
  endtask

  task automatic test_sw_then_lw();
    int lat, wc; logic e, w1;
    run(1'b1, 3'b010, 32'h28, 32'hDEADBEEF, lat, wc, e, w1);
    total++; if (lat !== 2 || wc !== 1 || w1 !== 1'b1 || e !== 1'b0) begin bad++;
      $display("FAIL sw_timing got=lat%0d we%0d we1%b err%b want=lat2 we1 we1_1 err0",
               lat, wc, w1, e); end
    run(1'b0, 3'b010, 32'h28, 32'h0, lat, wc, e, w1);
    total++; if (lat !== 2 || rdata !== 32'hDEADBEEF) begin bad++;
      $display("FAIL sw_readback got=lat%0d %h want=lat2 DEADBEEF", lat, rdata); end
  endtask

  task automatic test_errors();
    logic        w   [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [2:0]  f3  [5] = '{3'b010, 3'b001, 3'b010, 3'b011, 3'b100};
    logic [31:0] ad  [5] = '{32'h21, 32'h23, 32'h100, 32'h24, 32'h24};
    logic [31:0] snap [3];
    int lat, wc; logic e, w1;
    for (int i = 0; i < 5; i++) begin
      snap[0] = mem[8]; snap[1] = mem[9]; snap[2] = mem[10];
      run(w[i], f3[i], ad[i], 32'h5A5A5A5A, lat, wc, e, w1);
      total++; if (lat !== 1 || e !== 1'b1) begin bad++;
        $display("FAIL err%0d_done got=lat%0d err%b want=lat1 err1", i, lat, e); end
      total++; if (wc !== 0) begin bad++;
        $display("FAIL err%0d_mem_we got=%0d want=0", i, wc); end
      total++; if (rdata !== 32'hDEADBEEF) begin bad++;
        $display("FAIL err%0d_rdata got=%h want=DEADBEEF", i, rdata); end
      total++; if (mem[8] !== snap[0] || mem[9] !== snap[1] || mem[10] !== snap[2]) begin
        bad++; $display("FAIL err%0d_memory got=%h %h %h want=%h %h %h", i,
                        mem[8], mem[9], mem[10], snap[0], snap[1], snap[2]); end
    end
  endtask

  task automatic test_boundary();
    int lat, wc; logic e, w1;
    preload(6'd63, 32'hCAFEF00D);
    run(1'b0, 3'b010, 32'hFC, 32'h0, lat, wc, e, w1);
    total++; if (lat !== 2 || e !== 1'b0 || rdata !== 32'hCAFEF00D) begin bad++;
      $display("FAIL last_word got=lat%0d err%b %h want=lat2 err0 CAFEF00D", lat, e, rdata); end
  endtask

  task automatic test_reset_in_read();
    int dones = 0, wes = 0;
    preload(6'd8, 32'h12345678);
    @(negedge clk);
    req = 1'b1; we_req = 1'b1; funct3 = 3'b001; addr = 32'h20; wdata = 32'h0000BEEF;
    @(negedge clk);
    req = 1'b0;
    total++; if (busy !== 1'b1 || mem_we !== 1'b0) begin bad++;
      $display("FAIL rst_read_entry got=busy%b we%b want=busy1 we0", busy, mem_we); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++; if (busy !== 1'b0) begin bad++;
      $display("FAIL rst_read_busy got=%b want=0", busy); end
    for (int n = 0; n < 5; n++) begin
      if (done) dones++;
      if (mem_we) wes++;
      @(negedge clk);
    end
    total++; if (dones !== 0 || wes !== 0 || mem[8] !== 32'h12345678) begin bad++;
      $display("FAIL rst_read_quiet got=done%0d we%0d %h want=done0 we0 12345678",
               dones, wes, mem[8]); end
  endtask

  task automatic test_back_to_back();
    int dones = 0, lat, wc; logic e, w1;
    preload(6'd8, 32'h12345678);
    preload(6'd11, 32'h0BADF00D);
    @(negedge clk);
    req = 1'b1; we_req = 1'b1; funct3 = 3'b000; addr = 32'h20; wdata = 32'h00000011;
    @(negedge clk);
    // Hold a different store request while busy; it must be dropped.
    we_req = 1'b1; funct3 = 3'b010; addr = 32'h2C; wdata = 32'h55555555;
    for (int n = 1; n <= 3; n++) begin
      if (done) dones++;
      if (n < 3) @(negedge clk);
    end
    req = 1'b0;
    total++; if (dones !== 1 || done !== 1'b1) begin bad++;
      $display("FAIL busy_single_done got=%0d done_at3=%b want=1 1", dones, done); end
    run(1'b0, 3'b010, 32'h20, 32'h0, lat, wc, e, w1);
    total++; if (lat !== 2 || rdata !== 32'h12345611) begin bad++;
      $display("FAIL b2b_load got=lat%0d %h want=lat2 12345611", lat, rdata); end
    total++; if (mem[11] !== 32'h0BADF00D) begin bad++;
      $display("FAIL busy_req_dropped got=%h want=0BADF00D", mem[11]); end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_subword_stores();
    test_sw_then_lw();
    test_errors();
    test_boundary();
    test_reset_in_read();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
